// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB controller sharing one ALU,
// with registered IR/A/B/ALUOut/MDR and external async-read instruction and data memories.
module multicycle_datapath #(
   parameter int          PC_W     = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter bit          OVF_TRAP = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [PC_W-1:0] dmem_addr,
   output logic [31:0]     dmem_wdata,
   output logic            dmem_we,
   input  logic [31:0]     dmem_rdata,
   input  logic [4:0]      dbg_ra,
   output logic [31:0]     dbg_rdata,
   output logic [PC_W-1:0] pc,
   output logic            retire,
   output logic            overflow,
   output logic            halted
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                          OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_BEQ = 6'h04, OP_J   = 6'h02;
   localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                          F_AND = 6'h24, F_OR   = 6'h25, F_SLT = 6'h2A;

   state_t          state_r;
   logic [PC_W-1:0] pc_r;
   logic [31:0]     ir_r, a_r, b_r, aluout_r, mdr_r;
   logic            dmem_we_r, retire_r, overflow_r, halted_r;
   logic [31:0]     gpr_r [32];

   logic [5:0]  op_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s, wb_dst_s;
   logic [15:0] imm_s;
   logic [31:0] sext_s, zext_s, pc_ext_s, br_tgt_s, jump_tgt_s, wb_data_s;
   logic [31:0] alu_res_s;
   logic        alu_ovf_s;

   // Returns 1 for every encoding the core implements; everything else halts.
   function automatic logic is_legal(input logic [31:0] ir);
      logic ok;
      case (ir[31:26])
         OP_RTYPE: begin
            case (ir[5:0])
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: ok = 1'b1;
               default:                                          ok = 1'b0;
            endcase
         end
         OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
         default:                                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign op_s       = ir_r[31:26];
   assign rs_s       = ir_r[25:21];
   assign rt_s       = ir_r[20:16];
   assign rd_s       = ir_r[15:11];
   assign funct_s    = ir_r[5:0];
   assign imm_s      = ir_r[15:0];
   assign sext_s     = {{16{imm_s[15]}}, imm_s};
   assign zext_s     = {16'h0000, imm_s};
   assign pc_ext_s   = 32'(pc_r);
   // Branch target is formed in DECODE, when pc already points past the branch.
   assign br_tgt_s   = pc_ext_s + {sext_s[29:0], 2'b00};
   assign jump_tgt_s = {pc_ext_s[31:28], ir_r[25:0], 2'b00};
   assign wb_dst_s   = (op_s == OP_RTYPE) ? rd_s : rt_s;
   assign wb_data_s  = (op_s == OP_LW) ? mdr_r : aluout_r;

   // Shared ALU for EXEC: result plus signed-overflow flag for add/sub/addi.
   always_comb begin
      alu_res_s = 32'h0;
      alu_ovf_s = 1'b0;
      case (op_s)
         OP_RTYPE: begin
            case (funct_s)
               F_ADD: begin
                  alu_res_s = a_r + b_r;
                  alu_ovf_s = (a_r[31] == b_r[31]) && (alu_res_s[31] != a_r[31]);
               end
               F_ADDU: alu_res_s = a_r + b_r;
               F_SUB: begin
                  alu_res_s = a_r - b_r;
                  alu_ovf_s = (a_r[31] != b_r[31]) && (alu_res_s[31] != a_r[31]);
               end
               F_SUBU: alu_res_s = a_r - b_r;
               F_AND:  alu_res_s = a_r & b_r;
               F_OR:   alu_res_s = a_r | b_r;
               F_SLT:  alu_res_s = {31'd0, ($signed(a_r) < $signed(b_r))};
               default: alu_res_s = 32'h0;
            endcase
         end
         OP_ADDI: begin
            alu_res_s = a_r + sext_s;
            alu_ovf_s = (a_r[31] == sext_s[31]) && (alu_res_s[31] != a_r[31]);
         end
         OP_ORI:        alu_res_s = a_r | zext_s;
         OP_LUI:        alu_res_s = {imm_s, 16'h0000};
         OP_LW, OP_SW:  alu_res_s = a_r + sext_s;
         default:       alu_res_s = 32'h0;
      endcase
   end

   // Controller and datapath registers; pulse outputs are registered one state ahead.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_FETCH;
         pc_r       <= RESET_PC[PC_W-1:0];
         ir_r       <= 32'h0;
         a_r        <= 32'h0;
         b_r        <= 32'h0;
         aluout_r   <= 32'h0;
         mdr_r      <= 32'h0;
         dmem_we_r  <= 1'b0;
         retire_r   <= 1'b0;
         overflow_r <= 1'b0;
         halted_r   <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            gpr_r[i] <= 32'h0;
         end
      end else begin
         dmem_we_r  <= 1'b0;
         retire_r   <= 1'b0;
         overflow_r <= 1'b0;
         case (state_r)
            S_FETCH: begin
               ir_r    <= imem_rdata;
               pc_r    <= pc_r + PC_W'(32'd4);
               state_r <= S_DECODE;
            end
            S_DECODE: begin
               if (is_legal(ir_r)) begin
                  a_r      <= gpr_r[rs_s];
                  b_r      <= gpr_r[rt_s];
                  aluout_r <= br_tgt_s;
                  retire_r <= (op_s == OP_BEQ) || (op_s == OP_J);
                  state_r  <= S_EXEC;
               end else begin
                  halted_r <= 1'b1;
                  state_r  <= S_HALT;
               end
            end
            S_EXEC: begin
               case (op_s)
                  OP_BEQ: begin
                     if (a_r == b_r) begin
                        pc_r <= aluout_r[PC_W-1:0];
                     end
                     state_r <= S_FETCH;
                  end
                  OP_J: begin
                     pc_r    <= jump_tgt_s[PC_W-1:0];
                     state_r <= S_FETCH;
                  end
                  OP_LW: begin
                     aluout_r <= alu_res_s;
                     state_r  <= S_MEM;
                  end
                  OP_SW: begin
                     aluout_r  <= alu_res_s;
                     dmem_we_r <= 1'b1;
                     retire_r  <= 1'b1;
                     state_r   <= S_MEM;
                  end
                  default: begin
                     aluout_r   <= alu_res_s;
                     retire_r   <= 1'b1;
                     overflow_r <= OVF_TRAP && alu_ovf_s;
                     state_r    <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (op_s == OP_LW) begin
                  mdr_r    <= dmem_rdata;
                  retire_r <= 1'b1;
                  state_r  <= S_WB;
               end else begin
                  state_r  <= S_FETCH;
               end
            end
            S_WB: begin
               // A trapped overflow is flagged in this same cycle and blocks the write.
               if ((wb_dst_s != 5'd0) && !overflow_r) begin
                  gpr_r[wb_dst_s] <= wb_data_s;
               end
               state_r <= S_FETCH;
            end
            S_HALT:  state_r <= S_HALT;
            default: state_r <= S_FETCH;
         endcase
      end
   end

   assign imem_addr  = pc_r;
   assign pc         = pc_r;
   assign dmem_addr  = aluout_r[PC_W-1:0];
   assign dmem_wdata = b_r;
   assign dmem_we    = dmem_we_r;
   assign retire     = retire_r;
   assign overflow   = overflow_r;
   assign halted     = halted_r;
   assign dbg_rdata  = (dbg_ra == 5'd0) ? 32'h0 : gpr_r[dbg_ra];
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: small programs in a bench-side memory,
// expected register/pc/strobe values hand-computed from the instruction set.
module tb_multicycle_datapath;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, dbg_rdata, pc;
   logic        dmem_we, retire, overflow, halted;
   logic [4:0]  dbg_ra;

   logic [31:0] imem [128];
   logic [31:0] dmem [64];
   int total = 0;
   int bad   = 0;

   multicycle_datapath #(.PC_W(32), .RESET_PC(32'h0), .OVF_TRAP(1'b1)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
      .dbg_ra(dbg_ra), .dbg_rdata(dbg_rdata),
      .pc(pc), .retire(retire), .overflow(overflow), .halted(halted)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem[imem_addr[8:2]];
   assign dmem_rdata = dmem[dmem_addr[7:2]];

   // Data memory write port
   always @(posedge clk) begin
      if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
   end

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic get_reg(input int idx, output logic [31:0] val);
      dbg_ra = 5'(idx);
      #1;
      val = dbg_rdata;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) imem[i] = 32'h0;
      for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic load_arith();
      clear_mem();
      imem[0] = enc_i(6'h0D, 0, 1, 16'h00FF);   // ori  $1,$0,0xFF
      imem[1] = enc_i(6'h0F, 0, 2, 16'h1234);   // lui  $2,0x1234
      imem[2] = enc_r(1, 2, 3, 6'h21);          // addu $3,$1,$2
      imem[3] = enc_i(6'h2B, 0, 3, 16'h0008);   // sw   $3,8($0)
      imem[4] = enc_i(6'h23, 0, 4, 16'h0008);   // lw   $4,8($0)
   endtask

   task automatic test_reset();
      logic [31:0] v;
      clear_mem();
      do_reset();
      get_reg(0, v);
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
      total++; if ({halted, dmem_we, retire, overflow} !== 4'b0000) begin bad++;
         $display("FAIL reset_flags got=%b want=%b", {halted, dmem_we, retire, overflow}, 4'b0000); end
      total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_r0 got=%h want=%h", v, 32'h0); end
   endtask

   task automatic test_alu_seq();
      logic [31:0] v;
      load_arith();
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         total++;
         if (retire !== ((k % 4) == 3)) begin bad++;
            $display("FAIL alu_retire cyc=%0d got=%b want=%b", k, retire, (k % 4) == 3); end
      end
      get_reg(1, v);
      total++; if (v !== 32'h000000FF) begin bad++; $display("FAIL ori_r1 got=%h want=%h", v, 32'h000000FF); end
      get_reg(2, v);
      total++; if (v !== 32'h12340000) begin bad++; $display("FAIL lui_r2 got=%h want=%h", v, 32'h12340000); end
      get_reg(3, v);
      total++; if (v !== 32'h123400FF) begin bad++; $display("FAIL addu_r3 got=%h want=%h", v, 32'h123400FF); end
   endtask

   task automatic test_mem();
      logic [31:0] v;
      load_arith();
      do_reset();
      tick(14);
      total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL sw_we_early got=%b want=0", dmem_we); end
      tick(1);
      total++; if ({dmem_we, retire} !== 2'b11) begin bad++;
         $display("FAIL sw_we got=%b want=%b", {dmem_we, retire}, 2'b11); end
      total++; if (dmem_addr !== 32'h8) begin bad++; $display("FAIL sw_addr got=%h want=%h", dmem_addr, 32'h8); end
      total++; if (dmem_wdata !== 32'h123400FF) begin bad++;
         $display("FAIL sw_data got=%h want=%h", dmem_wdata, 32'h123400FF); end
      tick(1);
      total++; if (dmem[2] !== 32'h123400FF) begin bad++;
         $display("FAIL sw_mem got=%h want=%h", dmem[2], 32'h123400FF); end
      for (int k = 17; k <= 20; k++) begin
         tick(1);
         total++;
         if ({dmem_we, retire} !== {1'b0, k == 20}) begin bad++;
            $display("FAIL lw_strobe cyc=%0d got=%b want=%b", k, {dmem_we, retire}, {1'b0, k == 20}); end
      end
      get_reg(4, v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL lw_early got=%h want=%h", v, 32'h0); end
      tick(1);
      get_reg(4, v);
      total++; if (v !== 32'h123400FF) begin bad++; $display("FAIL lw_r4 got=%h want=%h", v, 32'h123400FF); end
      total++; if (pc !== 32'h14) begin bad++; $display("FAIL lw_pc got=%h want=%h", pc, 32'h14); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      load_arith();
      do_reset();
      tick(19);
      do_reset();
      get_reg(3, v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_rst_r3 got=%h want=%h", v, 32'h0); end
      total++; if ({pc, halted, dmem_we, retire} !== {32'h0, 3'b000}) begin bad++;
         $display("FAIL mid_rst_state pc=%h flags=%b want pc=0 flags=000", pc, {halted, dmem_we, retire}); end
      tick(1);
      total++; if (pc !== 32'h4) begin bad++; $display("FAIL mid_rst_fetch got=%h want=%h", pc, 32'h4); end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      logic [31:0] want [16];
      clear_mem();
      imem[0] = enc_i(6'h08, 0, 5, 16'h7FFF);   // addi $5,$0,0x7FFF
      imem[1] = enc_i(6'h0F, 0, 6, 16'h7FFF);   // lui  $6,0x7FFF
      imem[2] = enc_r(6, 6, 7, 6'h20);          // add  $7  overflows
      imem[3] = enc_r(6, 6, 8, 6'h21);          // addu $8
      imem[4] = enc_r(6, 8, 9, 6'h2A);          // slt  $9
      imem[5] = enc_r(8, 6, 10, 6'h2A);         // slt  $10
      imem[6] = enc_r(8, 6, 11, 6'h22);         // sub  $11 overflows
      imem[7] = enc_r(8, 6, 12, 6'h23);         // subu $12
      imem[8] = enc_r(6, 8, 13, 6'h24);         // and  $13
      want[5] = 32'h00007FFF; want[6] = 32'h7FFF0000; want[7] = 32'h0; want[8] = 32'hFFFE0000;
      want[9] = 32'h0; want[10] = 32'h1; want[11] = 32'h0; want[12] = 32'h7FFF0000; want[13] = 32'h7FFE0000;
      do_reset();
      for (int k = 1; k <= 36; k++) begin
         tick(1);
         total++;
         if (overflow !== (k == 11 || k == 27)) begin bad++;
            $display("FAIL ovf_pulse cyc=%0d got=%b want=%b", k, overflow, k == 11 || k == 27); end
      end
      for (int r = 5; r <= 13; r++) begin
         get_reg(r, v);
         total++;
         if (v !== want[r]) begin bad++; $display("FAIL ovf_reg r%0d got=%h want=%h", r, v, want[r]); end
      end
   endtask

   task automatic test_branch();
      clear_mem();
      imem[0] = {6'h02, 26'h4};                 // j 0x4 -> 0x10
      imem[4] = enc_i(6'h04, 1, 1, 16'hFFFF);   // beq $1,$1,-1
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         total++;
         if (retire !== ((k % 3) == 2)) begin bad++;
            $display("FAIL br_retire cyc=%0d got=%b want=%b", k, retire, (k % 3) == 2); end
         if ((k % 3) == 0) begin
            total++;
            if (pc !== 32'h10) begin bad++; $display("FAIL br_pc cyc=%0d got=%h want=%h", k, pc, 32'h10); end
         end
      end
      clear_mem();
      imem[0] = {6'h02, 26'h40};                // j 0x40 -> 0x100
      do_reset();
      tick(3);
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL j_pc got=%h want=%h", pc, 32'h100); end
      clear_mem();
      imem[0] = enc_i(6'h0D, 0, 1, 16'h0001);   // ori $1,$0,1
      imem[1] = enc_i(6'h04, 1, 0, 16'hFFFF);   // beq $1,$0,-1 not taken
      do_reset();
      tick(7);
      total++; if (pc !== 32'h8) begin bad++; $display("FAIL beq_nt_pc got=%h want=%h", pc, 32'h8); end
   endtask

   task automatic test_halt();
      clear_mem();
      imem[0] = 32'hFC000000;
      do_reset();
      tick(1);
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b want=0", halted); end
      tick(1);
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b want=1", halted); end
      for (int k = 0; k < 8; k++) begin
         tick(1);
         total++;
         if ({halted, retire, dmem_we, pc} !== {3'b100, 32'h4}) begin bad++;
            $display("FAIL halt_hold cyc=%0d got h/r/we=%b pc=%h want 100 pc=4", k,
                     {halted, retire, dmem_we}, pc); end
      end
      do_reset();
      total++; if ({halted, pc} !== {1'b0, 32'h0}) begin bad++;
         $display("FAIL halt_clear got h=%b pc=%h want h=0 pc=0", halted, pc); end
   endtask

   initial begin
      rst = 1'b1;
      dbg_ra = 5'd0;
      test_reset();
      test_alu_seq();
      test_mem();
      test_reset_mid();
      test_overflow();
      test_branch();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
